// File: rtl/sparc_microsequencer.sv
// Hard-wired microsequencer for the SPARC-subset multicycle datapath.
// Moore FSM with registered outputs. Each control vector is computed from
// the next state, so the outputs always match the state register.
module sparc_microsequencer #(
  parameter logic [5:0] NOP_PASS = 6'h3E,
  parameter logic [5:0] OP_ADD   = 6'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic [31:0] PSR,
  input  logic [31:0] MAR,
  input  logic [31:0] MDR,
  input  logic [31:0] PC,
  input  logic [31:0] nPC,
  input  logic [31:0] TBR,
  input  logic [31:0] WIM,
  input  logic [31:0] TQ,
  input  logic [31:0] ALU,
  input  logic        MFC,
  output logic        IRE, MDRE, MARE, PCE, nPCE, TBRE, PSRE, WIME, tQE, RFE, ALUE,
  output logic        IRClr, ClrPC, nPCClr, tQClr,
  output logic        MFA, MOP_SEL,
  output logic        nPC_ADD, nPC_ADDSEL, TB_ADD, BAUX, ttAUX,
  output logic        RA_SEL, DISP_SEL, AOP_SEL,
  output logic        ET, PSR_SUPER, PSR_PREV_SUP,
  output logic [1:0]  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL, PSR_SEL, TBA_SEL,
  output logic [4:0]  CWP,
  output logic [5:0]  OP1,
  output logic [24:0] TBA_IN,
  output logic [5:0]  tQ_IN,
  output logic [31:0] MDR_AUX, MAR_AUX, WIM_IN
);

  typedef enum logic [4:0] {
    S_RST, S_INIT, S_F0, S_F1, S_F2, S_DEC,
    S_EX_ALU, S_EX_SETHI, S_EX_BR_T, S_EX_BR_N, S_EX_CALL,
    S_M0, S_M1, S_M2, S_M1S, S_M2S, S_ADV
  } state_t;

  typedef struct packed {
    logic ire, mdre, mare, pce, npce, tbre, psre, wime, tqe, rfe, alue;
    logic irclr, clrpc, npcclr, tqclr;
    logic mfa, mop_sel;
    logic npc_add, npc_addsel, tb_add, baux, ttaux;
    logic ra_sel, disp_sel, aop_sel;
    logic et, psr_super, psr_prev_sup;
    logic [1:0] npc_sel, alu_sel, cin_sel, rc_sel, mar_sel, mdr_sel, psr_sel, tba_sel;
    logic [4:0] cwp;
    logic [5:0] op1;
    logic [24:0] tba_in;
    logic [5:0] tq_in;
    logic [31:0] mdr_aux, mar_aux, wim_in;
  } ctl_t;

  state_t state, state_nxt;
  ctl_t   ctl;

  // Observation inputs not needed by this instruction subset.
  logic unused_obs;
  assign unused_obs = ^{MAR, MDR, PC, nPC, TBR, WIM, TQ, ALU,
                        IR[29], IR[18:14], IR[12:0], PSR[31:24], PSR[19:0]};

  // Integer condition codes; icc = {N, Z, V, C}.
  function automatic logic br_taken(input logic [3:0] cond, input logic [3:0] icc);
    logic n, z, v, c;
    {n, z, v, c} = icc;
    case (cond)
      4'h0: br_taken = 1'b0;
      4'h1: br_taken = z;
      4'h2: br_taken = z | (n ^ v);
      4'h3: br_taken = n ^ v;
      4'h4: br_taken = c | z;
      4'h5: br_taken = c;
      4'h6: br_taken = n;
      4'h7: br_taken = v;
      4'h8: br_taken = 1'b1;
      4'h9: br_taken = ~z;
      4'hA: br_taken = ~(z | (n ^ v));
      4'hB: br_taken = ~(n ^ v);
      4'hC: br_taken = ~(c | z);
      4'hD: br_taken = ~c;
      4'hE: br_taken = ~n;
      default: br_taken = ~v;
    endcase
  endfunction

  // Control vector presented while the FSM sits in state s.
  function automatic ctl_t ctl_for(input state_t s, input logic [31:0] ir);
    ctl_t c;
    c = '0;
    case (s)
      S_RST: begin
        c.irclr = 1'b1; c.clrpc = 1'b1; c.npcclr = 1'b1; c.tqclr = 1'b1;
      end
      S_INIT: begin
        c.psre = 1'b1; c.psr_sel = 2'b01; c.psr_super = 1'b1;
        c.npce = 1'b1; c.npc_sel = 2'b00;
      end
      S_F0: c.mare = 1'b1;
      S_F1, S_M1: begin
        c.mfa = 1'b1; c.mop_sel = 1'b1; c.mdre = 1'b1; c.mdr_sel = 2'b00;
      end
      S_F2: c.ire = 1'b1;
      S_EX_ALU: begin
        c.op1 = ir[24:19]; c.alu_sel = 2'b00; c.aop_sel = ir[13];
        c.alue = 1'b1; c.rfe = 1'b1; c.rc_sel = 2'b00;
      end
      S_EX_SETHI: begin
        c.ra_sel = 1'b1; c.op1 = NOP_PASS; c.alue = 1'b1; c.rfe = 1'b1;
      end
      S_EX_BR_T: begin
        c.pce = 1'b1; c.npce = 1'b1; c.npc_sel = 2'b01; c.disp_sel = 1'b0;
      end
      S_EX_CALL: begin
        c.alu_sel = 2'b01; c.op1 = NOP_PASS; c.alue = 1'b1; c.rfe = 1'b1;
        c.rc_sel = 2'b01; c.pce = 1'b1; c.npce = 1'b1; c.npc_sel = 2'b01;
        c.disp_sel = 1'b1;
      end
      S_M0: begin
        c.op1 = OP_ADD; c.alu_sel = 2'b00; c.aop_sel = ir[13]; c.alue = 1'b1;
        c.mare = 1'b1; c.mar_sel = 2'b01;
      end
      S_M2: begin
        c.alu_sel = 2'b10; c.op1 = NOP_PASS; c.alue = 1'b1; c.rfe = 1'b1;
        c.rc_sel = 2'b00;
      end
      S_M1S: begin
        c.mdre = 1'b1; c.mdr_sel = 2'b01;
      end
      S_M2S: c.mfa = 1'b1;
      S_ADV: begin
        c.pce = 1'b1; c.npce = 1'b1; c.npc_add = 1'b1; c.npc_addsel = 1'b0;
        c.npc_sel = 2'b00;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state sequencing: fetch, decode dispatch, memory waits on MFC.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  state_nxt = S_INIT;
      S_INIT: state_nxt = S_F0;
      S_F0:   state_nxt = S_F1;
      S_F1:   state_nxt = MFC ? S_F2 : S_F1;
      S_F2:   state_nxt = S_DEC;
      S_DEC: begin
        state_nxt = S_ADV;
        case (IR[31:30])
          2'b10: if (IR[24:19] <= 6'h04) state_nxt = S_EX_ALU;
          2'b00: begin
            if (IR[24:22] == 3'b100)      state_nxt = S_EX_SETHI;
            else if (IR[24:22] == 3'b010) state_nxt = br_taken(IR[28:25], PSR[23:20]) ? S_EX_BR_T : S_EX_BR_N;
          end
          2'b01: state_nxt = S_EX_CALL;
          default: if (IR[24:19] == 6'h00 || IR[24:19] == 6'h04) state_nxt = S_M0;
        endcase
      end
      S_EX_ALU, S_EX_SETHI, S_EX_BR_N, S_M2: state_nxt = S_ADV;
      S_EX_BR_T, S_EX_CALL, S_ADV:           state_nxt = S_F0;
      S_M0:  state_nxt = (IR[24:19] == 6'h00) ? S_M1 : S_M1S;
      S_M1:  state_nxt = MFC ? S_M2 : S_M1;
      S_M1S: state_nxt = S_M2S;
      S_M2S: state_nxt = MFC ? S_ADV : S_M2S;
      default: state_nxt = S_RST;
    endcase
  end

  // State and registered control outputs; reset aborts any wait immediately.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_RST;
      ctl   <= ctl_for(S_RST, 32'h0);
    end else begin
      state <= state_nxt;
      ctl   <= ctl_for(state_nxt, IR);
    end
  end

  assign {IRE, MDRE, MARE, PCE, nPCE, TBRE, PSRE, WIME, tQE, RFE, ALUE} =
         {ctl.ire, ctl.mdre, ctl.mare, ctl.pce, ctl.npce, ctl.tbre, ctl.psre,
          ctl.wime, ctl.tqe, ctl.rfe, ctl.alue};
  assign {IRClr, ClrPC, nPCClr, tQClr} = {ctl.irclr, ctl.clrpc, ctl.npcclr, ctl.tqclr};
  assign {MFA, MOP_SEL} = {ctl.mfa, ctl.mop_sel};
  assign {nPC_ADD, nPC_ADDSEL, TB_ADD, BAUX, ttAUX} =
         {ctl.npc_add, ctl.npc_addsel, ctl.tb_add, ctl.baux, ctl.ttaux};
  assign {RA_SEL, DISP_SEL, AOP_SEL} = {ctl.ra_sel, ctl.disp_sel, ctl.aop_sel};
  assign {ET, PSR_SUPER, PSR_PREV_SUP} = {ctl.et, ctl.psr_super, ctl.psr_prev_sup};
  assign {nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL} = {ctl.npc_sel, ctl.alu_sel, ctl.cin_sel, ctl.rc_sel};
  assign {MAR_SEL, MDR_SEL, PSR_SEL, TBA_SEL} = {ctl.mar_sel, ctl.mdr_sel, ctl.psr_sel, ctl.tba_sel};
  assign CWP     = ctl.cwp;
  assign OP1     = ctl.op1;
  assign TBA_IN  = ctl.tba_in;
  assign tQ_IN   = ctl.tq_in;
  assign MDR_AUX = ctl.mdr_aux;
  assign MAR_AUX = ctl.mar_aux;
  assign WIM_IN  = ctl.wim_in;

endmodule

// File: tb/tb_sparc_microsequencer.sv
// Testbench for sparc_microsequencer: an instruction-level model predicts the
// full control vector for every cycle of fetch/decode/execute.
module tb_sparc_microsequencer;

  localparam logic [5:0] NOP_PASS = 6'h3E;
  localparam logic [5:0] OP_ADD   = 6'h00;

  typedef struct packed {
    logic ire, mdre, mare, pce, npce, tbre, psre, wime, tqe, rfe, alue;
    logic irclr, clrpc, npcclr, tqclr;
    logic mfa, mop_sel;
    logic npc_add, npc_addsel, tb_add, baux, ttaux;
    logic ra_sel, disp_sel, aop_sel;
    logic et, psr_super, psr_prev_sup;
    logic [1:0] npc_sel, alu_sel, cin_sel, rc_sel, mar_sel, mdr_sel, psr_sel, tba_sel;
    logic [4:0] cwp;
    logic [5:0] op1;
    logic [24:0] tba_in;
    logic [5:0] tq_in;
    logic [31:0] mdr_aux, mar_aux, wim_in;
  } ctl_t;

  logic Clk = 1'b0;
  logic Reset;
  logic [31:0] IR, PSR;
  logic MFC;
  logic IRE, MDRE, MARE, PCE, nPCE, TBRE, PSRE, WIME, tQE, RFE, ALUE;
  logic IRClr, ClrPC, nPCClr, tQClr, MFA, MOP_SEL;
  logic nPC_ADD, nPC_ADDSEL, TB_ADD, BAUX, ttAUX, RA_SEL, DISP_SEL, AOP_SEL;
  logic ET, PSR_SUPER, PSR_PREV_SUP;
  logic [1:0] nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL, PSR_SEL, TBA_SEL;
  logic [4:0] CWP;
  logic [5:0] OP1, tQ_IN;
  logic [24:0] TBA_IN;
  logic [31:0] MDR_AUX, MAR_AUX, WIM_IN;

  ctl_t  act_c, exp_c;
  logic  chk_en = 1'b0;
  int    checks = 0;
  int    errors = 0;
  string phase = "idle";

  always #5 Clk = ~Clk;

  sparc_microsequencer #(.NOP_PASS(NOP_PASS), .OP_ADD(OP_ADD)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .PSR(PSR),
    .MAR(32'h0), .MDR(32'h0), .PC(32'h0), .nPC(32'h0), .TBR(32'h0),
    .WIM(32'h0), .TQ(32'h0), .ALU(32'h0), .MFC(MFC),
    .IRE(IRE), .MDRE(MDRE), .MARE(MARE), .PCE(PCE), .nPCE(nPCE), .TBRE(TBRE),
    .PSRE(PSRE), .WIME(WIME), .tQE(tQE), .RFE(RFE), .ALUE(ALUE),
    .IRClr(IRClr), .ClrPC(ClrPC), .nPCClr(nPCClr), .tQClr(tQClr),
    .MFA(MFA), .MOP_SEL(MOP_SEL), .nPC_ADD(nPC_ADD), .nPC_ADDSEL(nPC_ADDSEL),
    .TB_ADD(TB_ADD), .BAUX(BAUX), .ttAUX(ttAUX), .RA_SEL(RA_SEL),
    .DISP_SEL(DISP_SEL), .AOP_SEL(AOP_SEL), .ET(ET), .PSR_SUPER(PSR_SUPER),
    .PSR_PREV_SUP(PSR_PREV_SUP), .nPC_SEL(nPC_SEL), .ALU_SEL(ALU_SEL),
    .CIN_SEL(CIN_SEL), .RC_SEL(RC_SEL), .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL),
    .PSR_SEL(PSR_SEL), .TBA_SEL(TBA_SEL), .CWP(CWP), .OP1(OP1),
    .TBA_IN(TBA_IN), .tQ_IN(tQ_IN), .MDR_AUX(MDR_AUX), .MAR_AUX(MAR_AUX),
    .WIM_IN(WIM_IN)
  );

  assign act_c = {IRE, MDRE, MARE, PCE, nPCE, TBRE, PSRE, WIME, tQE, RFE, ALUE,
                  IRClr, ClrPC, nPCClr, tQClr, MFA, MOP_SEL,
                  nPC_ADD, nPC_ADDSEL, TB_ADD, BAUX, ttAUX, RA_SEL, DISP_SEL, AOP_SEL,
                  ET, PSR_SUPER, PSR_PREV_SUP,
                  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MAR_SEL, MDR_SEL, PSR_SEL, TBA_SEL,
                  CWP, OP1, TBA_IN, tQ_IN, MDR_AUX, MAR_AUX, WIM_IN};

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      checks++;
      if (act_c !== exp_c) begin
        errors++;
        $display("FAIL ctl[%s] t=%0t actual=%h required=%h", phase, $time, act_c, exp_c);
      end
    end
  end

  // ---------------- instruction-level model ----------------
  function automatic bit br_taken_m(input logic [3:0] cond, input logic [3:0] icc);
    bit n, z, v, c, base;
    n = icc[3]; z = icc[2]; v = icc[1]; c = icc[0];
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      default: base = v;
    endcase
    return base ^ cond[3];
  endfunction

  // 0 nop, 1 alu, 2 sethi, 3 bicc, 4 call, 5 ld, 6 st
  function automatic int kind(input logic [31:0] ins);
    logic [5:0] op3;
    op3 = ins[24:19];
    case (ins[31:30])
      2'b10: return (op3 <= 6'd4) ? 1 : 0;
      2'b00: return (ins[24:22] == 3'b100) ? 2 : (ins[24:22] == 3'b010) ? 3 : 0;
      2'b01: return 4;
      default: return (op3 == 6'd0) ? 5 : (op3 == 6'd4) ? 6 : 0;
    endcase
  endfunction

  function automatic ctl_t v_rst();
    ctl_t c = '0;
    c.irclr = 1; c.clrpc = 1; c.npcclr = 1; c.tqclr = 1;
    return c;
  endfunction
  function automatic ctl_t v_init();
    ctl_t c = '0;
    c.psre = 1; c.psr_sel = 2'b01; c.psr_super = 1; c.npce = 1;
    return c;
  endfunction
  function automatic ctl_t v_f0();
    ctl_t c = '0;
    c.mare = 1;
    return c;
  endfunction
  function automatic ctl_t v_read();
    ctl_t c = '0;
    c.mfa = 1; c.mop_sel = 1; c.mdre = 1;
    return c;
  endfunction
  function automatic ctl_t v_f2();
    ctl_t c = '0;
    c.ire = 1;
    return c;
  endfunction
  function automatic ctl_t v_adv();
    ctl_t c = '0;
    c.pce = 1; c.npce = 1; c.npc_add = 1;
    return c;
  endfunction

  // First execute-cycle vector for an instruction (ADV for NOPs).
  function automatic ctl_t ex_vec(input logic [31:0] ins, input logic [31:0] psr);
    ctl_t c = '0;
    case (kind(ins))
      1: begin c.op1 = ins[24:19]; c.aop_sel = ins[13]; c.alue = 1; c.rfe = 1; end
      2: begin c.ra_sel = 1; c.op1 = NOP_PASS; c.alue = 1; c.rfe = 1; end
      3: if (br_taken_m(ins[28:25], psr[23:20])) begin
           c.pce = 1; c.npce = 1; c.npc_sel = 2'b01;
         end
      4: begin
           c.alu_sel = 2'b01; c.op1 = NOP_PASS; c.alue = 1; c.rfe = 1; c.rc_sel = 2'b01;
           c.pce = 1; c.npce = 1; c.npc_sel = 2'b01; c.disp_sel = 1;
         end
      5, 6: begin
           c.op1 = OP_ADD; c.aop_sel = ins[13]; c.alue = 1; c.mare = 1; c.mar_sel = 2'b01;
         end
      default: c = v_adv();
    endcase
    return c;
  endfunction

  task automatic step(input ctl_t v, input int mfc);
    exp_c = v;
    MFC = (mfc < 0) ? 1'($urandom_range(0, 1)) : 1'(mfc);
    @(posedge Clk);
    #1;
  endtask

  task automatic mem_wait(input ctl_t v, input int lat);
    for (int i = 0; i < lat; i++) step(v, 0);
    step(v, 1);
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [31:0] psr,
                           input int lat_f, input int lat_m);
    ctl_t c;
    int k;
    k = kind(ins);
    $sformat(phase, "ins=%h k=%0d", ins, k);
    PSR = psr;
    step(v_f0(), -1);
    mem_wait(v_read(), lat_f);
    step(v_f2(), -1);
    IR = ins;
    step('0, -1);
    step(ex_vec(ins, psr), -1);
    case (k)
      1, 2: step(v_adv(), -1);
      3: if (!br_taken_m(ins[28:25], psr[23:20])) step(v_adv(), -1);
      5: begin
        mem_wait(v_read(), lat_m);
        c = '0; c.alu_sel = 2'b10; c.op1 = NOP_PASS; c.alue = 1; c.rfe = 1;
        step(c, -1);
        step(v_adv(), -1);
      end
      6: begin
        c = '0; c.mdre = 1; c.mdr_sel = 2'b01;
        step(c, -1);
        c = '0; c.mfa = 1;
        mem_wait(c, lat_m);
        step(v_adv(), -1);
      end
      default: ;
    endcase
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pin[%s] actual=%h required=%h", name, got, want);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: begin r[31:30] = 2'b10; r[24:19] = 6'($urandom_range(0, 5)); end
      1: begin r[31:30] = 2'b00; r[24:22] = 3'b100; end
      2: begin r[31:30] = 2'b00; r[24:22] = 3'b010; end
      3: r[31:30] = 2'b01;
      4: begin r[31:30] = 2'b11; r[24:19] = 6'd0; end
      5: begin r[31:30] = 2'b11; r[24:19] = 6'd4; end
      6: ;
      default: r[31:30] = 2'b10;
    endcase
    return r;
  endfunction

  initial begin
    ctl_t pv;
    Reset = 1'b0; IR = 32'h0; PSR = 32'h0; MFC = 1'b0; exp_c = '0;

    // Hand-computed pins on the model itself.
    pv = ex_vec(32'hA2044012, 32'h0);
    pin("add_ex", {19'h0, pv.op1, pv.rfe, pv.alue, pv.aop_sel, pv.rc_sel, pv.pce},
                  {19'h0, 6'h00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0});
    pin("be_z1", 32'(br_taken_m(4'h1, 4'b0100)), 32'd1);
    pin("be_z0", 32'(br_taken_m(4'h1, 4'b0000)), 32'd0);
    pin("bg_nv", 32'(br_taken_m(4'hA, 4'b1000)), 32'd0);
    pin("bgu_0", 32'(br_taken_m(4'hC, 4'b0000)), 32'd1);
    pin("ba",    32'(br_taken_m(4'h8, 4'b0000)), 32'd1);
    pv = ex_vec(32'h02800004, 32'h0040_0000);
    pin("be_taken_vec", {29'h0, pv.pce, pv.npc_sel}, {29'h0, 1'b1, 2'b01});
    pin("ld_kind", 32'(kind(32'hC4006008)), 32'd5);
    pin("st_kind", 32'(kind(32'hC4206008)), 32'd6);

    // Reset sequence.
    @(posedge Clk); #1;
    chk_en = 1'b1;
    phase = "reset";
    step(v_rst(), -1);
    Reset = 1'b1;
    step(v_rst(), -1);
    phase = "init";
    step(v_init(), -1);

    // Directed programme.
    run_instr(32'hA2044012, 32'h0, 1, 0);
    run_instr(32'h9C044012, 32'h0, 0, 0);
    run_instr(32'h02800004, 32'h0040_0000, 0, 0);
    run_instr(32'h02800004, 32'h0, 2, 0);
    run_instr(32'hC4006008, 32'h0, 1, 1);
    run_instr(32'hC4206008, 32'h0, 0, 2);
    run_instr(32'h40000010, 32'h0, 0, 0);
    run_instr(32'h03000123, 32'h0, 0, 0);
    run_instr(32'h8A2C4003, 32'h0, 0, 0);

    // Reset mid-fetch wait: outputs must drop to reset values with no edge.
    phase = "reset_in_f1";
    step(v_f0(), -1);
    step(v_read(), 0);
    Reset = 1'b0;
    exp_c = v_rst();
    MFC = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    step(v_rst(), -1);
    step(v_init(), -1);

    // Randomised instruction stream.
    for (int n = 0; n < 400; n++)
      run_instr(rand_instr(), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
